// File: rtl/cache_control_nway_if.sv
// Handshake and array-control bundle between the N-way cache controller and its
// CPU, datapath and physical-memory neighbours. The controller attaches as master.
interface cache_control_nway_if #(
  parameter int unsigned WAYS = 4
);
  localparam int unsigned WB = $clog2(WAYS);

  logic            mem_read;
  logic            mem_write;
  logic            mem_resp;
  logic [WAYS-1:0] hit_vec;
  logic [WAYS-1:0] valid_vec;
  logic [WAYS-1:0] dirty_vec;
  logic [WAYS-2:0] plru_in;
  logic [WAYS-2:0] plru_out;
  logic            ld_plru;
  logic [WAYS-1:0] ld_data;
  logic [WAYS-1:0] ld_tag;
  logic [WAYS-1:0] ld_valid;
  logic [WAYS-1:0] ld_dirty;
  logic            dirty_in;
  logic            data_sel;
  logic [WB-1:0]   way_sel;
  logic            addr_sel;
  logic            pmem_read;
  logic            pmem_write;
  logic            pmem_resp;

  modport master (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_in, pmem_resp,
    output mem_resp, plru_out, ld_plru, ld_data, ld_tag, ld_valid, ld_dirty, dirty_in,
           data_sel, way_sel, addr_sel, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_in, pmem_resp,
    input  mem_resp, plru_out, ld_plru, ld_data, ld_tag, ld_valid, ld_dirty, dirty_in,
           data_sel, way_sel, addr_sel, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back/write-allocate cache controller with tree PLRU
// replacement; the victim way is latched at miss time and held until the response.
module cache_control_nway #(
  parameter int unsigned WAYS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cache_control_nway_if.master bus
);
  localparam int unsigned WB = $clog2(WAYS);

  typedef enum logic [1:0] {StIdle, StWback, StFill, StResp} state_e;

  state_e        state_q, state_d;
  logic [WB-1:0] victim_q, victim_d;

  // Walk from the root following the stored bits; each bit becomes one way-index bit.
  function automatic logic [WB-1:0] plru_pick(input logic [WAYS-2:0] tree);
    logic [WB-1:0] node;
    logic [WB-1:0] way;
    logic          b;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < int'(WB); lvl++) begin
      b    = tree[node];
      way  = WB'({way, b});
      node = WB'(2 * node + 1 + b);
    end
    return way;
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                 input logic [WB-1:0]   way);
    logic [WAYS-2:0] t;
    logic [WB-1:0]   node;
    logic [WB-1:0]   w;
    logic            b;
    t    = tree;
    node = '0;
    w    = way;
    for (int lvl = 0; lvl < int'(WB); lvl++) begin
      b       = w[WB-1];
      t[node] = ~b;
      node    = WB'(2 * node + 1 + b);
      w       = w << 1;
    end
    return t;
  endfunction

  function automatic logic [WB-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WB-1:0] idx;
    idx = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (v[i]) idx = WB'(i);
    end
    return idx;
  endfunction

  logic            req;
  logic            hit;
  logic [WB-1:0]   hit_way;
  logic [WB-1:0]   cand;
  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] vic_oh;
  logic [WAYS-2:0] plru_hit;
  logic [WAYS-2:0] plru_vic;

  assign req      = bus.mem_read | bus.mem_write;
  assign hit      = |bus.hit_vec;
  assign hit_way  = lowest_set(bus.hit_vec);
  assign cand     = (&bus.valid_vec) ? plru_pick(bus.plru_in) : lowest_set(~bus.valid_vec);
  assign hit_oh   = WAYS'(1) << hit_way;
  assign vic_oh   = WAYS'(1) << victim_q;
  assign plru_hit = plru_touch(bus.plru_in, hit_way);
  assign plru_vic = plru_touch(bus.plru_in, victim_q);

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    bus.mem_resp   = 1'b0;
    bus.plru_out   = '0;
    bus.ld_plru    = 1'b0;
    bus.ld_data    = '0;
    bus.ld_tag     = '0;
    bus.ld_valid   = '0;
    bus.ld_dirty   = '0;
    bus.dirty_in   = 1'b0;
    bus.data_sel   = 1'b0;
    bus.way_sel    = '0;
    bus.addr_sel   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req && hit) begin
          bus.mem_resp = 1'b1;
          bus.way_sel  = hit_way;
          bus.ld_plru  = 1'b1;
          bus.plru_out = plru_hit;
          if (bus.mem_write) begin
            bus.ld_data  = hit_oh;
            bus.ld_dirty = hit_oh;
            bus.dirty_in = 1'b1;
          end
        end else if (req) begin
          victim_d = cand;
          state_d  = (bus.valid_vec[cand] && bus.dirty_vec[cand]) ? StWback : StFill;
        end
      end
      StWback: begin
        bus.pmem_write = 1'b1;
        bus.addr_sel   = 1'b1;
        bus.way_sel    = victim_q;
        if (bus.pmem_resp) begin
          bus.ld_dirty = vic_oh;
          state_d      = StFill;
        end
      end
      StFill: begin
        bus.pmem_read = 1'b1;
        bus.data_sel  = 1'b1;
        if (bus.pmem_resp) begin
          bus.ld_data  = vic_oh;
          bus.ld_tag   = vic_oh;
          bus.ld_valid = vic_oh;
          bus.ld_dirty = vic_oh;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (req) begin
          bus.mem_resp = 1'b1;
          bus.way_sel  = victim_q;
          bus.ld_plru  = 1'b1;
          bus.plru_out = plru_vic;
          if (bus.mem_write) begin
            bus.ld_data  = vic_oh;
            bus.ld_dirty = vic_oh;
            bus.dirty_in = 1'b1;
          end
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are forced quiet while reset is held, even against a live hit.
    if (!rst_n) begin
      bus.mem_resp   = 1'b0;
      bus.plru_out   = '0;
      bus.ld_plru    = 1'b0;
      bus.ld_data    = '0;
      bus.ld_tag     = '0;
      bus.ld_valid   = '0;
      bus.ld_dirty   = '0;
      bus.dirty_in   = 1'b0;
      bus.data_sel   = 1'b0;
      bus.way_sel    = '0;
      bus.addr_sel   = 1'b0;
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway: 4-way and 8-way instances, hand-computed expectations.
module tb_cache_control_nway;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cache_control_nway_if #(.WAYS(4)) bus4 ();
  cache_control_nway_if #(.WAYS(8)) bus8 ();

  cache_control_nway #(.WAYS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  cache_control_nway #(.WAYS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  wire [27:0] outs4 = {bus4.mem_resp, bus4.ld_plru, bus4.plru_out, bus4.ld_data, bus4.ld_tag,
                       bus4.ld_valid, bus4.ld_dirty, bus4.dirty_in, bus4.data_sel,
                       bus4.way_sel, bus4.addr_sel, bus4.pmem_read, bus4.pmem_write};
  wire [15:0] lds4  = {bus4.ld_data, bus4.ld_tag, bus4.ld_valid, bus4.ld_dirty};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle4();
    bus4.mem_read  = 1'b0;
    bus4.mem_write = 1'b0;
    bus4.hit_vec   = '0;
    bus4.valid_vec = '0;
    bus4.dirty_vec = '0;
    bus4.plru_in   = '0;
    bus4.pmem_resp = 1'b0;
  endtask

  task automatic idle8();
    bus8.mem_read  = 1'b0;
    bus8.mem_write = 1'b0;
    bus8.hit_vec   = '0;
    bus8.valid_vec = '0;
    bus8.dirty_vec = '0;
    bus8.plru_in   = '0;
    bus8.pmem_resp = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.mem_read = 1'b1;
    bus4.hit_vec  = 4'b0001;
    #1;
    checks++;
    if (outs4 !== 28'h0) begin
      errors++; $display("FAIL reset_quiet got %h expected %h", outs4, 28'h0);
    end
    idle4();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs4 !== 28'h0) begin
      errors++; $display("FAIL post_reset_idle got %h expected %h", outs4, 28'h0);
    end
    bus4.pmem_resp = 1'b1;
    tick();
    checks++;
    if (outs4 !== 28'h0) begin
      errors++; $display("FAIL idle_pmem_resp got %h expected %h", outs4, 28'h0);
    end
    bus4.pmem_resp = 1'b0;
  endtask

  task automatic test_read_hit();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b1111;
    bus4.hit_vec   = 4'b0100;
    bus4.plru_in   = 3'b000;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.way_sel, bus4.ld_plru, bus4.plru_out} !== {1'b1, 2'd2, 1'b1, 3'b100})
    begin
      errors++; $display("FAIL hit_w2 got %b expected %b",
        {bus4.mem_resp, bus4.way_sel, bus4.ld_plru, bus4.plru_out}, {1'b1, 2'd2, 1'b1, 3'b100});
    end
    checks++;
    if ({bus4.pmem_read, bus4.pmem_write, lds4} !== 18'h0) begin
      errors++; $display("FAIL hit_w2_quiet got %h expected %h",
        {bus4.pmem_read, bus4.pmem_write, lds4}, 18'h0);
    end
    bus4.plru_in = 3'b111;
    #1;
    checks++;
    if (bus4.plru_out !== 3'b110) begin
      errors++; $display("FAIL hit_w2_keep got %b expected %b", bus4.plru_out, 3'b110);
    end
    // Lowest index wins on a multi-hot match.
    bus4.hit_vec = 4'b1010;
    bus4.plru_in = 3'b000;
    #1;
    checks++;
    if ({bus4.way_sel, bus4.plru_out} !== {2'd1, 3'b001}) begin
      errors++; $display("FAIL hit_multi got %b expected %b",
        {bus4.way_sel, bus4.plru_out}, {2'd1, 3'b001});
    end
    idle4();
    tick();
  endtask

  task automatic test_clean_write_miss();
    bus4.mem_write = 1'b1;
    bus4.valid_vec = 4'b1011;
    bus4.dirty_vec = 4'b1111;
    #1;
    checks++;
    if (outs4 !== 28'h0) begin
      errors++; $display("FAIL miss_idle got %h expected %h", outs4, 28'h0);
    end
    tick();
    checks++;
    if ({bus4.pmem_read, bus4.pmem_write, bus4.data_sel, bus4.addr_sel, lds4} !== {4'b1010, 16'h0})
    begin
      errors++; $display("FAIL fill_enter got %h expected %h",
        {bus4.pmem_read, bus4.pmem_write, bus4.data_sel, bus4.addr_sel, lds4}, {4'b1010, 16'h0});
    end
    tick();
    tick();
    bus4.pmem_resp = 1'b1;
    #1;
    checks++;
    if ({lds4, bus4.dirty_in, bus4.mem_resp} !== {16'h4444, 2'b00}) begin
      errors++; $display("FAIL fill_done got %h expected %h",
        {lds4, bus4.dirty_in, bus4.mem_resp}, {16'h4444, 2'b00});
    end
    tick();
    bus4.pmem_resp = 1'b0;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.ld_dirty, bus4.dirty_in, bus4.ld_data, bus4.data_sel, bus4.way_sel}
        !== {1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2}) begin
      errors++; $display("FAIL resp_write got %b expected %b",
        {bus4.mem_resp, bus4.ld_dirty, bus4.dirty_in, bus4.ld_data, bus4.data_sel, bus4.way_sel},
        {1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2});
    end
    checks++;
    if ({bus4.ld_plru, bus4.plru_out, bus4.pmem_read} !== {1'b1, 3'b100, 1'b0}) begin
      errors++; $display("FAIL resp_plru got %b expected %b",
        {bus4.ld_plru, bus4.plru_out, bus4.pmem_read}, {1'b1, 3'b100, 1'b0});
    end
    idle4();
    tick();
    checks++;
    if (outs4 !== 28'h0) begin
      errors++; $display("FAIL back_idle got %h expected %h", outs4, 28'h0);
    end
  endtask

  task automatic test_dirty_read_miss();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b1111;
    bus4.dirty_vec = 4'b0010;
    bus4.plru_in   = 3'b010;
    tick();
    checks++;
    if ({bus4.pmem_write, bus4.pmem_read, bus4.addr_sel, bus4.way_sel} !== {3'b101, 2'd1}) begin
      errors++; $display("FAIL wback got %b expected %b",
        {bus4.pmem_write, bus4.pmem_read, bus4.addr_sel, bus4.way_sel}, {3'b101, 2'd1});
    end
    tick();
    bus4.pmem_resp = 1'b1;
    #1;
    checks++;
    if ({bus4.ld_dirty, bus4.dirty_in, bus4.ld_data, bus4.ld_valid} !== {4'b0010, 1'b0, 8'h0})
    begin
      errors++; $display("FAIL wback_done got %b expected %b",
        {bus4.ld_dirty, bus4.dirty_in, bus4.ld_data, bus4.ld_valid}, {4'b0010, 1'b0, 8'h0});
    end
    tick();
    bus4.pmem_resp = 1'b0;
    bus4.valid_vec = 4'b0000;
    #1;
    checks++;
    if ({bus4.pmem_read, bus4.pmem_write, bus4.addr_sel} !== 3'b100) begin
      errors++; $display("FAIL wback_to_fill got %b expected %b",
        {bus4.pmem_read, bus4.pmem_write, bus4.addr_sel}, 3'b100);
    end
    bus4.pmem_resp = 1'b1;
    #1;
    checks++;
    if (bus4.ld_valid !== 4'b0010) begin
      errors++; $display("FAIL fill_victim_held got %b expected %b", bus4.ld_valid, 4'b0010);
    end
    tick();
    bus4.pmem_resp = 1'b0;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.way_sel, bus4.ld_plru, bus4.plru_out, bus4.ld_data, bus4.ld_dirty}
        !== {1'b1, 2'd1, 1'b1, 3'b001, 8'h0}) begin
      errors++; $display("FAIL resp_read got %b expected %b",
        {bus4.mem_resp, bus4.way_sel, bus4.ld_plru, bus4.plru_out, bus4.ld_data, bus4.ld_dirty},
        {1'b1, 2'd1, 1'b1, 3'b001, 8'h0});
    end
    idle4();
    tick();
  endtask

  task automatic test_ways8_hit();
    bus8.mem_write = 1'b1;
    bus8.valid_vec = 8'hff;
    bus8.hit_vec   = 8'b0011_0000;
    #1;
    checks++;
    if ({bus8.mem_resp, bus8.way_sel, bus8.ld_dirty, bus8.ld_data, bus8.dirty_in}
        !== {1'b1, 3'd4, 8'h10, 8'h10, 1'b1}) begin
      errors++; $display("FAIL w8_hit got %b expected %b",
        {bus8.mem_resp, bus8.way_sel, bus8.ld_dirty, bus8.ld_data, bus8.dirty_in},
        {1'b1, 3'd4, 8'h10, 8'h10, 1'b1});
    end
    checks++;
    if ({bus8.ld_plru, bus8.plru_out} !== {1'b1, 7'h24}) begin
      errors++; $display("FAIL w8_plru got %b expected %b",
        {bus8.ld_plru, bus8.plru_out}, {1'b1, 7'h24});
    end
    idle8();
    tick();
  endtask

  task automatic test_reset_mid_fill();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b0111;
    tick();
    checks++;
    if (bus4.pmem_read !== 1'b1) begin
      errors++; $display("FAIL rfill_enter got %b expected %b", bus4.pmem_read, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    bus4.pmem_resp = 1'b1;
    #1;
    checks++;
    if ({bus4.pmem_read, bus4.mem_resp, lds4} !== 18'h0) begin
      errors++; $display("FAIL rfill_abort got %h expected %h",
        {bus4.pmem_read, bus4.mem_resp, lds4}, 18'h0);
    end
    idle4();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b1111;
    bus4.hit_vec   = 4'b0001;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.way_sel, bus4.plru_out, bus4.pmem_read} !== {1'b1, 2'd0, 3'b011, 1'b0})
    begin
      errors++; $display("FAIL rfill_hit got %b expected %b",
        {bus4.mem_resp, bus4.way_sel, bus4.plru_out, bus4.pmem_read}, {1'b1, 2'd0, 3'b011, 1'b0});
    end
    idle4();
    tick();
  endtask

  task automatic test_drop_during_fill();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b1110;
    tick();
    bus4.mem_read = 1'b0;
    tick();
    bus4.pmem_resp = 1'b1;
    #1;
    checks++;
    if (bus4.ld_valid !== 4'b0001) begin
      errors++; $display("FAIL drop_fill got %b expected %b", bus4.ld_valid, 4'b0001);
    end
    tick();
    bus4.pmem_resp = 1'b0;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.ld_plru, lds4} !== 18'h0) begin
      errors++; $display("FAIL drop_resp got %h expected %h",
        {bus4.mem_resp, bus4.ld_plru, lds4}, 18'h0);
    end
    tick();
    bus4.mem_read  = 1'b1;
    bus4.valid_vec = 4'b1111;
    bus4.hit_vec   = 4'b1000;
    #1;
    checks++;
    if ({bus4.mem_resp, bus4.way_sel, bus4.plru_out} !== {1'b1, 2'd3, 3'b000}) begin
      errors++; $display("FAIL drop_then_hit got %b expected %b",
        {bus4.mem_resp, bus4.way_sel, bus4.plru_out}, {1'b1, 2'd3, 3'b000});
    end
    idle4();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle4();
    idle8();
    #2;
    test_reset();
    test_read_hit();
    test_clean_write_miss();
    test_dirty_read_miss();
    test_ways8_hit();
    test_reset_mid_fill();
    test_drop_during_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
